// File: rtl/led_array_ctrl_if.sv
// Config write port for led_array_ctrl: valid/ready write request carrying
// channel, mode and value, plus the error pulse for out-of-range channels.
//   master : drives cfg_valid/cfg_chan/cfg_mode/cfg_value, sees cfg_ready/cfg_err
//   slave  : the LED controller side
interface led_array_ctrl_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_value;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_chan, cfg_mode, cfg_value,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_mode, cfg_value,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/led_array_ctrl.sv
// Multi-channel LED controller. Each channel runs OFF, ON, BLINK (half-period
// in prescaler ticks) or PWM (duty against a shared free-running phase).
//   clk, reset : system clock, asynchronous active-high reset
//   cfg        : config write port (slave side of led_array_ctrl_if)
//   tick       : one-cycle strobe every CLK_HZ/TICK_HZ clocks
//   led        : registered active-high LED drive, one bit per channel
module led_array_ctrl #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned CLK_HZ   = 24_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    led_array_ctrl_if.slave     cfg,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);
    localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    logic [PS_W-1:0]  ps_cnt;
    logic [PWM_W-1:0] phase;
    mode_t            mode  [NUM_LEDS];
    logic [CNT_W-1:0] value [NUM_LEDS];
    logic [CNT_W-1:0] cnt   [NUM_LEDS];
    logic [NUM_LEDS-1:0] blink;
    logic [NUM_LEDS-1:0] led_d;
    logic             wr;
    logic             chan_ok;

    assign wr      = cfg.cfg_valid && cfg.cfg_ready;
    assign chan_ok = (32'(cfg.cfg_chan) < NUM_LEDS);

    // Ready comes up on the first edge after reset and never drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_err   <= 1'b0;
        end else begin
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= wr && !chan_ok;
        end
    end

    // Prescaler runs once ready is up, so the first tick lands PRESCALE edges
    // after release; tick is registered one count early to line up with P-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (cfg.cfg_ready) begin
            ps_cnt <= (ps_cnt == PS_W'(PRESCALE - 1)) ? '0 : ps_cnt + PS_W'(1);
            tick   <= (ps_cnt == PS_W'(PRESCALE - 2));
        end
    end

    // Shared PWM phase, free-running from reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else begin
            phase <= phase + PWM_W'(1);
        end
    end

    // Per-channel mode/value/blink state; a write to a channel takes
    // priority over a tick landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                mode[i]  <= MODE_OFF;
                value[i] <= '0;
                cnt[i]   <= '0;
            end
            blink <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                if (wr && chan_ok && (32'(cfg.cfg_chan) == 32'(i))) begin
                    mode[i]  <= mode_t'(cfg.cfg_mode);
                    value[i] <= cfg.cfg_value;
                    cnt[i]   <= '0;
                    blink[i] <= 1'b0;
                end else if (mode[i] == MODE_BLINK && tick) begin
                    if (cnt[i] == value[i]) begin
                        cnt[i]   <= '0;
                        blink[i] <= ~blink[i];
                    end else begin
                        cnt[i]   <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // LED drive decode from the current channel state.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            case (mode[i])
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink[i];
                MODE_PWM:   led_d[i] = (phase < value[i][PWM_W-1:0]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end
endmodule

// File: tb/tb_led_array_ctrl.sv
// Bench for led_array_ctrl: a cycle model pushes the expected outputs of the
// coming edge into a queue; they are popped and compared just after the edge.
// A second 3-channel instance exercises the out-of-range channel error.
module tb_led_array_ctrl;
    localparam int P  = 10;
    localparam int PH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_array_ctrl_if #(.CH_W(2), .CNT_W(16)) cfg_if ();
    led_array_ctrl_if #(.CH_W(2), .CNT_W(16)) cfg3_if ();

    logic       tick;
    logic       tick3;
    logic [3:0] led;
    logic [2:0] led3;

    led_array_ctrl #(.NUM_LEDS(4), .CLK_HZ(1000), .TICK_HZ(100), .CNT_W(16), .PWM_W(4)) dut (
        .clk(clk), .reset(reset), .cfg(cfg_if), .tick(tick), .led(led));

    led_array_ctrl #(.NUM_LEDS(3), .CLK_HZ(1000), .TICK_HZ(100), .CNT_W(16), .PWM_W(4)) dut3 (
        .clk(clk), .reset(reset), .cfg(cfg3_if), .tick(tick3), .led(led3));

    typedef struct packed {
        logic [3:0] led;
        logic       tick;
        logic       err;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: values after m_n edges since reset release.
    int          m_n;
    logic        m_ready;
    logic [1:0]  m_mode [4];
    logic [15:0] m_val  [4];
    logic [15:0] m_cnt  [4];
    logic [3:0]  m_blink;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n     = 0;
        m_ready = 1'b0;
        m_blink = '0;
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 2'd0;
            m_val[i]  = '0;
            m_cnt[i]  = '0;
        end
    endtask

    // Predict the next edge from the model and the held inputs, then advance.
    task automatic step();
        exp_t e;
        logic tick_now;
        logic acc;
        logic [3:0] duty;
        int   ph;
        int   ch;
        tick_now = (m_n > 0) && (m_n % P == 0);
        ph       = m_n % PH;
        acc      = cfg_if.cfg_valid && m_ready;
        ch       = int'(cfg_if.cfg_chan);
        for (int i = 0; i < 4; i++) begin
            duty = m_val[i][3:0];
            case (m_mode[i])
                2'd1:    e.led[i] = 1'b1;
                2'd2:    e.led[i] = m_blink[i];
                2'd3:    e.led[i] = (ph < int'(duty));
                default: e.led[i] = 1'b0;
            endcase
        end
        e.tick  = ((m_n + 1) % P == 0);
        e.err   = 1'b0;
        e.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (acc && ch == i) begin
                m_mode[i]  = cfg_if.cfg_mode;
                m_val[i]   = cfg_if.cfg_value;
                m_cnt[i]   = '0;
                m_blink[i] = 1'b0;
            end else if (m_mode[i] == 2'd2 && tick_now) begin
                if (m_cnt[i] == m_val[i]) begin
                    m_cnt[i]   = '0;
                    m_blink[i] = ~m_blink[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 16'd1;
                end
            end
        end
        m_ready = 1'b1;
        m_n++;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check("led",   32'(led),              32'(e.led));
            check("tick",  32'(tick),             32'(e.tick));
            check("err",   32'(cfg_if.cfg_err),   32'(e.err));
            check("ready", 32'(cfg_if.cfg_ready), 32'(e.ready));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input logic [1:0] chan, input logic [1:0] mode, input logic [15:0] val);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = chan;
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_value = val;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Count led[3] highs over 16 consecutive cycles.
    task automatic pwm_count(output int highs);
        highs = 0;
        for (int i = 0; i < PH; i++) begin
            step();
            if (led[3]) highs++;
        end
    endtask

    int first_tick;
    int highs;
    int rise;
    int guard;

    initial begin
        reset             = 1'b1;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_chan   = '0;
        cfg_if.cfg_mode   = '0;
        cfg_if.cfg_value  = '0;
        cfg3_if.cfg_valid = 1'b0;
        cfg3_if.cfg_chan  = '0;
        cfg3_if.cfg_mode  = '0;
        cfg3_if.cfg_value = '0;
        last_exp          = '0;
        model_reset();

        // Held in reset: everything low, not ready.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_led",   32'(led),              32'd0);
        check("rst_tick",  32'(tick),             32'd0);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("rst_err",   32'(cfg_if.cfg_err),   32'd0);

        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Tick cadence: first tick on edge 10, then every 10.
        first_tick = -1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (tick && first_tick < 0) first_tick = i;
        end
        check("first_tick_edge", 32'(first_tick), 32'd10);

        // Out-of-range channel on the 3-channel instance.
        cfg3_if.cfg_valid = 1'b1;
        cfg3_if.cfg_chan  = 2'd3;
        cfg3_if.cfg_mode  = 2'd1;
        step();
        cfg3_if.cfg_valid = 1'b0;
        check("err3_pulse", 32'(cfg3_if.cfg_err), 32'd1);
        check("err3_led",   32'(led3),            32'd0);
        step();
        check("err3_clear", 32'(cfg3_if.cfg_err), 32'd0);
        check("err3_led2",  32'(led3),            32'd0);
        cfg3_if.cfg_valid = 1'b1;
        cfg3_if.cfg_chan  = 2'd2;
        step();
        cfg3_if.cfg_valid = 1'b0;
        check("err3_valid_chan", 32'(cfg3_if.cfg_err), 32'd0);
        step();
        check("led3_on", 32'(led3), 32'b100);
        check("err3_quiet", 32'(cfg3_if.cfg_err), 32'd0);

        // chan1 ON, chan2 BLINK half-period 3 ticks.
        write(2'd1, 2'd1, 16'd0);
        step();
        check("on_led1", 32'(led[1]), 32'd1);
        write(2'd2, 2'd2, 16'd2);
        steps(130);

        // chan3 PWM duty 4/16, then 0, then 0x1F (upper bits ignored).
        write(2'd3, 2'd3, 16'd4);
        steps(2);
        pwm_count(highs);
        check("pwm_duty4", 32'(highs), 32'd4);
        write(2'd3, 2'd3, 16'd0);
        steps(2);
        pwm_count(highs);
        check("pwm_duty0", 32'(highs), 32'd0);
        write(2'd3, 2'd3, 16'h1F);
        steps(2);
        pwm_count(highs);
        check("pwm_duty15", 32'(highs), 32'd15);

        // chan0 BLINK value 0, then rewrite on the edge that consumes a tick.
        write(2'd0, 2'd2, 16'd0);
        steps(25);
        guard = 0;
        while (!((m_n > 0) && (m_n % P == 0)) && guard < 2 * P) begin
            step();
            guard++;
        end
        write(2'd0, 2'd2, 16'd0);
        rise = -1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (led[0] && rise < 0) rise = i;
        end
        check("tick_write_toggle_delay", 32'(rise), 32'd11);

        // Async reset mid-blink while led[2] is high.
        guard = 0;
        while (!last_exp.led[2] && guard < 100) begin
            step();
            guard++;
        end
        check("led2_high_before_reset", 32'(led[2]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_led",   32'(led),              32'd0);
        check("async_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("async_rst_tick",  32'(tick),             32'd0);
        @(posedge clk);
        #1;
        check("hold_rst_led", 32'(led), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        steps(40);
        check("post_rst_led", 32'(led), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
